lcd_seq_ctrl: RTL and testbench

//   Hardware sequencer for the HD44780-style character LCD, placed on the

---
 rtl/lcd_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_lcd_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_seq_ctrl.sv
// Sequencer for an HD44780-style character LCD: runs the power-up init sequence,
// then issues one command or character per handshake with legal RS/EN/DATA timing.
module lcd_seq_ctrl #(
    parameter int T_PWR  = 750000,
    parameter int T_SU   = 2,
    parameter int T_EN   = 12,
    parameter int T_EXEC = 2000,
    parameter int T_CLR  = 82000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    output logic       req_ready_o,
    output logic       init_done_o,
    output logic       lcd_on_o,
    output logic       lcd_en_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic [7:0] lcd_data_o
);

    localparam int T_MAX_A = (T_PWR > T_CLR) ? T_PWR : T_CLR;
    localparam int T_MAX_B = (T_EXEC > T_EN) ? T_EXEC : T_EN;
    localparam int T_MAX_C = (T_MAX_B > T_SU) ? T_MAX_B : T_SU;
    localparam int T_MAX   = (T_MAX_A > T_MAX_C) ? T_MAX_A : T_MAX_C;
    localparam int CW      = $clog2(T_MAX) + 1;

    // Each state spends its load value + 1 cycles; PWR_WAIT also spends the
    // cycle that raises lcd_on_o and loads the counter, hence the -2.
    localparam logic [CW-1:0] LD_PWR  = CW'(T_PWR - 2);
    localparam logic [CW-1:0] LD_SU   = CW'(T_SU - 1);
    localparam logic [CW-1:0] LD_EN   = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_EXEC = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_CLR  = CW'(T_CLR - 1);

    localparam logic [2:0] PWR_WAIT  = 3'd0;
    localparam logic [2:0] INIT_LOAD = 3'd1;
    localparam logic [2:0] SETUP     = 3'd2;
    localparam logic [2:0] PULSE     = 3'd3;
    localparam logic [2:0] EXEC      = 3'd4;
    localparam logic [2:0] IDLE      = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    init_idx;
    logic          long_exec;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    init_rom = 8'h38;
            2'd1:    init_rom = 8'h0C;
            2'd2:    init_rom = 8'h01;
            default: init_rom = 8'h06;
        endcase
    endfunction

    // Clear and return-home commands need the long execution wait.
    assign long_exec = !lcd_rs_o && (lcd_data_o == 8'h01 || lcd_data_o == 8'h02 ||
                                     lcd_data_o == 8'h03);
    assign lcd_rw_o  = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= PWR_WAIT;
            cnt         <= '0;
            init_idx    <= 2'd0;
            req_ready_o <= 1'b0;
            init_done_o <= 1'b0;
            lcd_on_o    <= 1'b0;
            lcd_en_o    <= 1'b0;
            lcd_rs_o    <= 1'b0;
            lcd_data_o  <= 8'h00;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (!lcd_on_o) begin
                        lcd_on_o <= 1'b1;
                        cnt      <= LD_PWR;
                    end else if (cnt == '0) begin
                        state <= INIT_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                INIT_LOAD: begin
                    lcd_rs_o   <= 1'b0;
                    lcd_data_o <= init_rom(init_idx);
                    cnt        <= LD_SU;
                    state      <= SETUP;
                end
                SETUP: begin
                    if (cnt == '0) begin
                        lcd_en_o <= 1'b1;
                        cnt      <= LD_EN;
                        state    <= PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        lcd_en_o <= 1'b0;
                        cnt      <= long_exec ? LD_CLR : LD_EXEC;
                        state    <= EXEC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!init_done_o && init_idx != 2'd3) begin
                        init_idx <= init_idx + 2'd1;
                        state    <= INIT_LOAD;
                    end else begin
                        init_done_o <= 1'b1;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        lcd_rs_o    <= req_rs_i;
                        lcd_data_o  <= req_data_i;
                        cnt         <= LD_SU;
                        state       <= SETUP;
                    end
                end
                default: begin
                    lcd_en_o    <= 1'b0;
                    req_ready_o <= 1'b0;
                    state       <= PWR_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Scoreboard bench for lcd_seq_ctrl: stimulus pushes expected EN pulses and
// ready-low durations, a negedge monitor pops and compares them.
module tb_lcd_seq_ctrl;

    localparam int T_PWR  = 20;
    localparam int T_SU   = 2;
    localparam int T_EN   = 4;
    localparam int T_EXEC = 10;
    localparam int T_CLR  = 30;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    int checks = 0;
    int errors = 0;

    pulse_t exp_pulse[$];
    int     exp_low[$];
    logic [7:0] init_list[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_seq_ctrl #(
        .T_PWR(T_PWR), .T_SU(T_SU), .T_EN(T_EN), .T_EXEC(T_EXEC), .T_CLR(T_CLR)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_rs_i(req_rs),
        .req_data_i(req_data),
        .req_ready_o(req_ready),
        .init_done_o(init_done),
        .lcd_on_o(lcd_on),
        .lcd_en_o(lcd_en),
        .lcd_rs_o(lcd_rs),
        .lcd_rw_o(lcd_rw),
        .lcd_data_o(lcd_data)
    );

    always #5 clk = ~clk;

    // Reference model: execution wait is decided purely by the command rules.
    function automatic int exec_wait(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return T_CLR;
        return T_EXEC;
    endfunction

    function automatic int init_cycles();
        int total = T_PWR;
        foreach (init_list[i]) total += 1 + T_SU + T_EN + exec_wait(1'b0, init_list[i]);
        return total;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_init();
        pulse_t p;
        foreach (init_list[i]) begin
            p.rs   = 1'b0;
            p.data = init_list[i];
            exp_pulse.push_back(p);
        end
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < budget) begin
            n++;
            @(negedge clk);
        end
        check_output("ready_timeout", req_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits for acceptance and records the expected response.
    task automatic apply_stimulus(input logic r, input logic [7:0] d, input bit keep_valid);
        int n = 0;
        pulse_t p;
        req_valid = 1'b1;
        req_rs    = r;
        req_data  = d;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_output("accept_timeout", req_ready, 1'b1);
        if (req_ready) begin
            p.rs   = r;
            p.data = d;
            exp_pulse.push_back(p);
            exp_low.push_back(T_SU + T_EN + exec_wait(r, d));
        end
        @(posedge clk);
        #1;
        if (!keep_valid) req_valid = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_init();
    endtask

    // Monitor: pulse shape/content, ready-low duration and init latency.
    bit         prev_en, waiting, init_seen;
    int         en_width, low_cnt, init_cnt;
    always @(negedge clk) begin
        if (rst) begin
            prev_en   = 1'b0;
            waiting   = 1'b0;
            init_seen = 1'b0;
            en_width  = 0;
            low_cnt   = 0;
            init_cnt  = 0;
            exp_pulse.delete();
            exp_low.delete();
        end else begin
            if (!init_seen) begin
                if (init_cnt == 0) check_output("lcd_on_first", lcd_on, 1'b0);
                if (init_cnt == 1) check_output("lcd_on_after", lcd_on, 1'b1);
                if (init_done) begin
                    init_seen = 1'b1;
                    check_output("init_latency", init_cnt, init_cycles());
                    check_output("ready_at_init", req_ready, 1'b1);
                end else begin
                    check_output("ready_before_init", req_ready, 1'b0);
                    init_cnt++;
                end
            end
            if (lcd_en && !prev_en) begin
                en_width = 1;
                check_output("pulse_expected", exp_pulse.size() > 0, 1'b1);
                check_output("rw_low", lcd_rw, 1'b0);
                if (exp_pulse.size() > 0) begin
                    check_output("rise_rs", lcd_rs, exp_pulse[0].rs);
                    check_output("rise_data", lcd_data, exp_pulse[0].data);
                end
            end else if (lcd_en) begin
                en_width++;
            end
            if (!lcd_en && prev_en && exp_pulse.size() > 0) begin
                check_output("fall_rs", lcd_rs, exp_pulse[0].rs);
                check_output("fall_data", lcd_data, exp_pulse[0].data);
                check_output("pulse_width", en_width, T_EN);
                void'(exp_pulse.pop_front());
            end
            prev_en = lcd_en;
            if (waiting) begin
                if (!req_ready) begin
                    low_cnt++;
                end else begin
                    waiting = 1'b0;
                    check_output("ready_expected", exp_low.size() > 0, 1'b1);
                    if (exp_low.size() > 0) check_output("ready_low_len", low_cnt, exp_low.pop_front());
                end
            end
            if (req_ready && req_valid) begin
                waiting = 1'b1;
                low_cnt = 0;
            end
        end
    end

    initial begin
        int gap;
        logic r;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_ready", req_ready, 1'b0);
        check_output("rst_done", init_done, 1'b0);
        check_output("rst_on", lcd_on, 1'b0);
        check_output("rst_en", lcd_en, 1'b0);
        check_output("rst_rs", lcd_rs, 1'b0);
        check_output("rst_rw", lcd_rw, 1'b0);
        check_output("rst_data", lcd_data, 8'h00);

        release_reset();
        wait_ready(400);

        apply_stimulus(1'b1, 8'h41, 1'b0);
        check_output("ready_drop", req_ready, 1'b0);
        wait_ready(200);

        apply_stimulus(1'b0, 8'h01, 1'b0);
        wait_ready(200);
        apply_stimulus(1'b1, 8'h01, 1'b0);
        wait_ready(200);
        apply_stimulus(1'b0, 8'h02, 1'b0);
        wait_ready(200);
        apply_stimulus(1'b0, 8'h03, 1'b0);
        wait_ready(200);

        apply_stimulus(1'b1, 8'h5A, 1'b0);
        req_valid = 1'b1;
        req_rs    = 1'b0;
        req_data  = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("busy_data_held", lcd_data, 8'h5A);
        check_output("busy_rs_held", lcd_rs, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_ready(200);

        apply_stimulus(1'b1, 8'h42, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (!lcd_en && n < 100) begin
                n++;
                @(negedge clk);
            end
            check_output("en_timeout", lcd_en, 1'b1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("midrst_en", lcd_en, 1'b0);
        check_output("midrst_ready", req_ready, 1'b0);
        check_output("midrst_done", init_done, 1'b0);
        check_output("midrst_on", lcd_on, 1'b0);
        release_reset();
        wait_ready(400);

        apply_stimulus(1'b1, 8'h61, 1'b1);
        apply_stimulus(1'b1, 8'h62, 1'b1);
        apply_stimulus(1'b1, 8'h63, 1'b0);
        wait_ready(200);

        for (int i = 0; i < 25; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            #1;
            r = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            apply_stimulus(r, d, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b1;
                req_data  = 8'($urandom_range(0, 255));
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        wait_ready(200);
        repeat (2) @(negedge clk);
        check_output("pulses_left", exp_pulse.size(), 0);
        check_output("ready_left", exp_low.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
